// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/DIV engine owning the HI/LO registers, with MTHI/MTLO writes and MFHI/MFLO reads.
// Ports: clk/resetn (async active-low), flush (abort in-flight op or drop an idle request),
//   req_valid/req_ready/req_op/src_a/src_b (request), busy/done (status),
//   hi_read/lo_read/rdata (read mux), hi_out/lo_out (committed HI/LO).
// Macro HILO_FAST_MULT_EN: MULT/MULTU complete in one cycle; the divide path stays iterative.
module hilo_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic              done,
  input  logic              hi_read,
  input  logic              lo_read,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);
  localparam int W = DATA_W;
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, BUSY_MUL, BUSY_DIV, FINISH} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0] hi_q, lo_q, opb;
  logic [2*W-1:0] acc, prod_fix;
  logic is_div, sa, sb, div0;
  logic accept, op_mul, op_div, op_signed, sa_in, sb_in, start_mul, start_div, stepping, commit;
  logic [W-1:0] a_abs, b_abs, q_fix, r_fix;
  logic [W:0] mul_sum, div_trial;
  assign accept    = req_valid && req_ready && !flush;
  assign op_mul    = req_op == 3'd1 || req_op == 3'd2;
  assign op_div    = req_op == 3'd3 || req_op == 3'd4;
  assign op_signed = req_op == 3'd1 || req_op == 3'd3;
  assign sa_in     = op_signed && src_a[W-1];
  assign sb_in     = op_signed && src_b[W-1];
  assign a_abs     = sa_in ? -src_a : src_a;
  assign b_abs     = sb_in ? -src_b : src_b;
  assign start_div = accept && op_div;
  assign stepping  = state == BUSY_MUL || state == BUSY_DIV;
  assign commit    = state == FINISH && !flush;
`ifdef HILO_FAST_MULT_EN
  logic fast_done;
  logic [2*W-1:0] fast_mag, fast_prod;
  assign start_mul = 1'b0;
  assign fast_mag  = {{W{1'b0}}, a_abs} * {{W{1'b0}}, b_abs};
  assign fast_prod = (sa_in ^ sb_in) ? -fast_mag : fast_mag;
`else
  assign start_mul = accept && op_mul;
`endif
  // acc holds {partial product high, multiplier} for mul and {remainder, dividend/quotient} for div.
  assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
  assign div_trial = {acc[2*W-1:W], acc[W-1]} - {1'b0, opb};
  assign prod_fix  = (sa ^ sb) ? -acc : acc;
  // Divide by zero: the remainder path already ends holding |src_a|, so restoring the dividend sign yields src_a.
  assign q_fix     = div0 ? '1 : ((sa ^ sb) ? -acc[W-1:0] : acc[W-1:0]);
  assign r_fix     = sa ? -acc[2*W-1:W] : acc[2*W-1:W];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (state == IDLE) state_nx = start_mul ? BUSY_MUL : start_div ? BUSY_DIV : IDLE;
    else if (state == FINISH) state_nx = IDLE;
    else if (cnt == '0) state_nx = FINISH;
  end
  always_comb begin
    req_ready = state == IDLE;
    busy      = state != IDLE;
`ifdef HILO_FAST_MULT_EN
    done      = commit || fast_done;
`else
    done      = commit;
`endif
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      div0   <= 1'b0;
`ifdef HILO_FAST_MULT_EN
      fast_done <= 1'b0;
`endif
    end else begin
      if (accept && req_op == 3'd5) hi_q <= src_a;
      if (accept && req_op == 3'd6) lo_q <= src_a;
      if (start_mul || start_div) begin
        acc    <= {{W{1'b0}}, a_abs};
        opb    <= b_abs;
        sa     <= sa_in;
        sb     <= sb_in;
        is_div <= op_div;
        div0   <= src_b == '0;
        cnt    <= CW'(W - 1);
      end else if (stepping) begin
        acc <= state == BUSY_MUL ? {mul_sum, acc[W-1:1]} :
               div_trial[W] ? {acc[2*W-2:0], 1'b0} : {div_trial[W-1:0], acc[W-2:0], 1'b1};
        cnt <= cnt - 1'b1;
      end
      if (commit) {hi_q, lo_q} <= is_div ? {r_fix, q_fix} : prod_fix;
`ifdef HILO_FAST_MULT_EN
      fast_done <= accept && op_mul;
      if (accept && op_mul) {hi_q, lo_q} <= fast_prod;
`endif
    end
  end
  assign rdata  = hi_read ? hi_q : lo_read ? lo_q : '0;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage consumer of the decoder's HI/LO control outputs.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles using an iterative datapath.
- Executes MTHI/MTLO writes in a single cycle.
- Owns the architectural HI/LO registers and serves MFHI/MFLO reads.
- Drives busy so the pipeline can stall HI/LO consumers until results commit.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
clk  in  1  clock, rising edge. Single clock; reset is asynchronous and active-low.
resetn  in  1  asynchronous active-low reset.
flush  in  1  synchronous abort of any in-flight operation.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request (state IDLE).
req_op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
src_a  in  DATA_W  rs value (dividend / multiplicand / MTHI-MTLO data).
src_b  in  DATA_W  rt value (divisor / multiplier).
busy  out  1  multi-cycle operation in flight.
done  out  1  one-cycle pulse when a MULT/DIV result commits.
hi_read  in  1  MFHI read select.
lo_read  in  1  MFLO read select.
rdata  out  DATA_W  combinational: HI if hi_read, else LO if lo_read, else 0.
hi_out  out  DATA_W  committed HI.
lo_out  out  DATA_W  committed LO.

Behaviour:
- Reset values: HI=LO=0, state IDLE, counter 0, busy=0, done=0, req_ready=1.
- States and transitions:
  - IDLE: req_ready=1.
  - BUSY_MUL / BUSY_DIV: counter runs DATA_W-1 down to 0.
  - FINISH: sign correction and commit.
- Accept on req_valid && req_ready at edge E.
- MTHI/MTLO: HI or LO takes src_a at edge E. No busy, no done.
- NOP and op 7: accepted, no effect.
- MULT/MULTU/DIV/DIVU:
  - Latch absolute operand values at E; signed ops also latch sign flags.
  - One shift-add (mul) or restoring-subtract (div) step per cycle, edges E+1..E+DATA_W.
  - Enter FINISH after the last step.
  - During FINISH: done=1. Apply sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - HI/LO written at edge E+DATA_W+1, then return to IDLE.
- busy=1 and req_ready=0 in BUSY_* and FINISH. Requests in those states are ignored.
- Mul result: HI = upper product word, LO = lower product word. Div result: LO = quotient, HI = remainder.
- Divide by zero (src_b=0, signed or unsigned): LO=all-ones, HI=src_a. No sign correction, no exception, same latency.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- rdata, hi_out and lo_out reflect committed values only; intermediate values are never visible.
- flush:
  - In BUSY_* or FINISH: return to IDLE next edge. HI/LO unchanged, done not asserted.
  - In IDLE together with req_valid: flush wins and the request is dropped, including MTHI/MTLO.
- resetn low at any time: immediate return to reset values. An in-flight result is lost.
- hi_read and lo_read both high: HI is returned.

Optional Feature:
- Macro: HILO_FAST_MULT_EN.
- Defined:
  - MULT/MULTU use a single-cycle full-width product and write HI/LO at acceptance edge E.
  - done pulses in cycle E+1; busy never asserted for multiplies.
  - BUSY_MUL state unused.
  - Divide path unchanged.
- Undefined: iterative multiply as above, DATA_W+1 cycle latency.

Test Plan:
1. MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> done in cycle E+33 (iterative build); HI=0xFFFFFFFE, LO=0x00000001. Fast build: done in cycle E+1, same values.
2. MULT src_a=0xFFFFFFFD (-3), src_b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU src_a=7, src_b=0 -> LO=0xFFFFFFFF, HI=7. DIV src_a=0x80000000, src_b=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MTHI 0x12345678 -> hi_read=1 next cycle gives rdata=0x12345678, no done. MTLO 0xCAFEBABE then lo_read -> rdata=0xCAFEBABE.
5. DIVU 100/7 started, MTLO 0xDEAD issued while busy -> MTLO ignored, req_ready=0; final LO=14, HI=2.
6. flush on 10th busy cycle of DIV -> HI/LO keep prior values, no done, req_ready=1 next cycle. resetn low mid-MULT -> HI=LO=0 and busy=0 immediately.
